// File: rtl/aes_key_sched_if.sv
// Handshake and read-port bundle for the AES-128 key scheduler.
// The slave side is the scheduler; the master side is its client.
interface aes_key_sched_if;
    logic         start;
    logic [127:0] key_in;
    logic [3:0]   rd_idx;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         done;
    logic         key_ready;
    logic [127:0] rd_key;

    modport slave (
        input  start, key_in, rd_idx,
        output busy, rk_valid, rk_idx, rk, done, key_ready, rd_key
    );

    modport master (
        output start, key_in, rd_idx,
        input  busy, rk_valid, rk_idx, rk, done, key_ready, rd_key
    );
endinterface

// File: rtl/aes_key_sched.sv
// AES-128 key expansion: one round key per cycle into an 11-entry store,
// streamed out on rk/rk_idx and readable afterwards through rd_idx/rd_key.
module aes_key_sched (
    input  logic             clk,
    input  logic             rst_n,
    aes_key_sched_if.slave   bus
);
    typedef enum logic {ST_IDLE, ST_EXPAND} state_t;

    state_t       r_state;
    logic [3:0]   r_round;
    logic [127:0] r_store [0:10];
    logic [127:0] r_rk;
    logic [3:0]   r_rk_idx;
    logic         r_valid;
    logic         r_busy;
    logic         r_done;
    logic         r_key_ready;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] inv;
        p   = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // During EXPAND, r_rk always holds round key r-1, so it seeds the next round.
    logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next;

    assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
    assign w_t    = sub_word({w_w3[23:0], w_w3[31:24]}) ^ {rcon(r_round), 24'h0};
    assign w_n0   = w_w0 ^ w_t;
    assign w_n1   = w_w1 ^ w_n0;
    assign w_n2   = w_w2 ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;
    assign w_next = {w_n0, w_n1, w_n2, w_n3};

    // NOTE: the key store sits under the async reset because a reset must leave every entry reading 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_round     <= 4'd0;
            r_rk        <= '0;
            r_rk_idx    <= 4'd0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_key_ready <= 1'b0;
            for (int i = 0; i < 11; i++) r_store[i] <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every register samples pre-edge values.
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_store[0]  <= bus.key_in;
                        r_rk        <= bus.key_in;
                        r_rk_idx    <= 4'd0;
                        r_valid     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_key_ready <= 1'b0;
                        r_round     <= 4'd1;
                        r_state     <= ST_EXPAND;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    r_store[r_round] <= w_next;
                    r_rk             <= w_next;
                    r_rk_idx         <= r_round;
                    r_valid          <= 1'b1;
                    r_busy           <= 1'b1;
                    if (r_round == 4'd10) begin
                        r_done      <= 1'b1;
                        r_key_ready <= 1'b1;
                        r_round     <= 4'd0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.rk_valid  = r_valid;
    assign bus.rk_idx    = r_rk_idx;
    assign bus.rk        = r_rk;
    assign bus.done      = r_done;
    assign bus.key_ready = r_key_ready;
    assign bus.rd_key    = (bus.rd_idx <= 4'd10) ? r_store[bus.rd_idx] : '0;
endmodule
